// File: rtl/comb_decim_fir.sv
// ============================================================================
// Module  : comb_decim_fir
// Brief   : Decimating transposed-form FIR with compile-time coefficients.
//           Define DECIM_FIR_SAT_EN to saturate (and flag) the output instead
//           of wrapping it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module comb_decim_fir #(
    parameter int                      IN_W   = 8,
    parameter int                      COEF_W = 10,
    parameter int                      TAPS   = 4,
    parameter logic [TAPS*COEF_W-1:0]  COEFFS = {10'sd0, 10'sd120, 10'sd336, 10'sd56},
    parameter int                      DECIM  = 2,
    parameter int                      OUT_W  = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_data,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int ACC_W = IN_W + COEF_W + $clog2(TAPS);
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] c_ph_last = PH_W'(DECIM - 1);

    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_prod [TAPS];
    logic signed [ACC_W-1:0] w_y;
    logic signed [OUT_W-1:0] w_conv;
    logic                    w_sat;
    logic                    w_emit;

    logic signed [ACC_W-1:0] r_s [1:TAPS-1];
    logic [PH_W-1:0]         r_phase;

    // Both multiplier operands are sign-extended to the accumulator width,
    // so the truncated product is exact.
    assign w_x = ACC_W'(in_data);

    for (genvar k = 0; k < TAPS; k++) begin : g_prod
        localparam logic signed [ACC_W-1:0] c_coef =
            ACC_W'($signed(COEFFS[k*COEF_W +: COEF_W]));
        assign w_prod[k] = w_x * c_coef;
    end

    assign w_y    = w_prod[0] + r_s[1];
    assign w_emit = in_valid & ~clr & (r_phase == '0);

`ifdef DECIM_FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] c_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_min = ~c_max;

    always_comb begin
        w_conv = w_y[OUT_W-1:0];
        w_sat  = 1'b0;
        if (w_y > c_max) begin
            w_conv = {1'b0, {(OUT_W-1){1'b1}}};
            w_sat  = 1'b1;
        end else if (w_y < c_min) begin
            w_conv = {1'b1, {(OUT_W-1){1'b0}}};
            w_sat  = 1'b1;
        end
    end

    logic r_sat;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_emit) begin
            r_sat <= w_sat;
        end
    end
    assign out_sat = r_sat;
`else
    assign w_conv  = w_y[OUT_W-1:0];
    assign w_sat   = 1'b0;
    assign out_sat = w_sat;

    if (OUT_W < ACC_W) begin : g_unused
        logic w_unused;
        assign w_unused = ^w_y[ACC_W-1:OUT_W];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < TAPS; k++) r_s[k] <= '0;
            r_phase   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clr) begin
            for (int k = 1; k < TAPS; k++) r_s[k] <= '0;
            r_phase   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                for (int k = 1; k < TAPS - 1; k++) r_s[k] <= w_prod[k] + r_s[k+1];
                r_s[TAPS-1] <= w_prod[TAPS-1];
                r_phase     <= (r_phase == c_ph_last) ? '0 : r_phase + 1'b1;
            end
            if (w_emit) begin
                out_valid <= 1'b1;
                out_data  <= w_conv;
            end
        end
    end

endmodule

`default_nettype wire
